// File: rtl/mem_access_unit.sv
// mem_access_unit: load/store front-end for DataMemory in the MEM stage.
// Takes one byte/half/word request at a time, checks alignment and turns it
// into word-aligned MemRead/MemWrite cycles. Sub-word stores are done as
// read-modify-write. Sub-word loads are sign- or zero-extended.
//
// Ports:
//   clk, rst_n          clock, synchronous active-low reset
//   req_*               request handshake and fields (valid/ready, write,
//                       size, unsigned, addr, right-aligned wdata)
//   resp_*              one-cycle completion pulse with load data / error
//   MemRead, MemWrite,
//   Address, WriteData  word-wide port to DataMemory (Address word-aligned)
//   ReadData            combinational read data from DataMemory
module mem_access_unit (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_write,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_error,
  output logic        MemRead,
  output logic        MemWrite,
  output logic [31:0] Address,
  output logic [31:0] WriteData,
  input  logic [31:0] ReadData
);

  localparam int unsigned DW = 32;
  localparam logic [1:0] SZ_BYTE = 2'b00;
  localparam logic [1:0] SZ_HALF = 2'b01;
  localparam logic [1:0] SZ_WORD = 2'b10;
  localparam logic [1:0] SZ_ILL  = 2'b11;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RD   = 2'd1,
    S_WR   = 2'd2,
    S_RESP = 2'd3
  } state_e;

  state_e          state_q, state_d;
  logic            rdy_en_q;
  logic            write_q, write_d;
  logic [1:0]      size_q, size_d;
  logic            uns_q, uns_d;
  logic            err_q, err_d;
  logic [DW-1:0]   addr_q, addr_d;
  // Holds store data from accept, then the read word (load) or the merged
  // word (sub-word store) from the RD-exit edge onwards.
  logic [DW-1:0]   word_q, word_d;

  logic            accept;
  logic            req_err;
  logic [DW-1:0]   merged;
  logic [DW-1:0]   ld_data;
  logic [7:0]      ld_byte;
  logic [15:0]     ld_half;

  assign accept  = req_valid && req_ready;
  assign req_err = (req_size == SZ_ILL) ||
                   ((req_size == SZ_HALF) && req_addr[0]) ||
                   ((req_size == SZ_WORD) && (req_addr[1:0] != 2'b00));

  // State register; rdy_en_q keeps req_ready low until an edge sees rst_n high
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= S_IDLE;
      rdy_en_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      rdy_en_q <= 1'b1;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      S_IDLE: begin
        if (accept) begin
          if (req_err)                                   state_d = S_RESP;
          else if (req_write && (req_size == SZ_WORD))   state_d = S_WR;
          else                                           state_d = S_RD;
        end
      end
      S_RD:    state_d = write_q ? S_WR : S_RESP;
      S_WR:    state_d = S_RESP;
      S_RESP:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  // Request/data registers
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      write_q <= 1'b0;
      size_q  <= 2'b00;
      uns_q   <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      word_q  <= '0;
    end else begin
      write_q <= write_d;
      size_q  <= size_d;
      uns_q   <= uns_d;
      err_q   <= err_d;
      addr_q  <= addr_d;
      word_q  <= word_d;
    end
  end

  // Latch request at accept; capture read/merged word when leaving RD
  always_comb begin
    write_d = write_q;
    size_d  = size_q;
    uns_d   = uns_q;
    err_d   = err_q;
    addr_d  = addr_q;
    word_d  = word_q;
    if (accept) begin
      write_d = req_write;
      size_d  = req_size;
      uns_d   = req_unsigned;
      err_d   = req_err;
      addr_d  = req_addr;
      word_d  = req_wdata;
    end else if (state_q == S_RD) begin
      word_d = write_q ? merged : ReadData;
    end
  end

  // Store lane replaced with right-aligned store data, other lanes kept
  always_comb begin
    merged = ReadData;
    case (size_q)
      SZ_BYTE: merged[{addr_q[1:0], 3'b000} +: 8]  = word_q[7:0];
      SZ_HALF: merged[{addr_q[1], 4'b0000} +: 16]  = word_q[15:0];
      default: merged = word_q;
    endcase
  end

  // Load lane extraction and extension
  assign ld_byte = word_q[{addr_q[1:0], 3'b000} +: 8];
  assign ld_half = word_q[{addr_q[1], 4'b0000} +: 16];

  always_comb begin
    ld_data = word_q;
    case (size_q)
      SZ_BYTE: ld_data = {{24{~uns_q & ld_byte[7]}}, ld_byte};
      SZ_HALF: ld_data = {{16{~uns_q & ld_half[15]}}, ld_half};
      default: ld_data = word_q;
    endcase
  end

  // Output decode from state
  always_comb begin
    req_ready  = 1'b0;
    resp_valid = 1'b0;
    resp_rdata = '0;
    resp_error = 1'b0;
    MemRead    = 1'b0;
    MemWrite   = 1'b0;
    Address    = '0;
    WriteData  = '0;
    case (state_q)
      S_IDLE: req_ready = rdy_en_q;
      S_RD: begin
        MemRead = 1'b1;
        Address = {addr_q[31:2], 2'b00};
      end
      S_WR: begin
        MemWrite  = 1'b1;
        Address   = {addr_q[31:2], 2'b00};
        WriteData = word_q;
      end
      S_RESP: begin
        Address    = {addr_q[31:2], 2'b00};
        resp_valid = 1'b1;
        resp_error = err_q;
        if (!write_q && !err_q) resp_rdata = ld_data;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Testbench for mem_access_unit: small word memory standing in for
// DataMemory, a reference model of memory contents and load results,
// directed scenarios followed by randomized transactions.
module tb_mem_access_unit;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;
  logic        MemRead;
  logic        MemWrite;
  logic [31:0] Address;
  logic [31:0] WriteData;
  logic [31:0] ReadData;

  int tests = 0;
  int fails = 0;

  logic [31:0] mem     [16] = '{default: 32'h0};
  logic [31:0] ref_mem [16];

  always #5 clk = ~clk;

  mem_access_unit dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_write    (req_write),
    .req_size     (req_size),
    .req_unsigned (req_unsigned),
    .req_addr     (req_addr),
    .req_wdata    (req_wdata),
    .resp_valid   (resp_valid),
    .resp_rdata   (resp_rdata),
    .resp_error   (resp_error),
    .MemRead      (MemRead),
    .MemWrite     (MemWrite),
    .Address      (Address),
    .WriteData    (WriteData),
    .ReadData     (ReadData)
  );

  // DataMemory stand-in: combinational read, write commits on the clock edge
  assign ReadData = MemRead ? mem[Address[5:2]] : 32'hBAD0_BAD0;
  always @(posedge clk) if (MemWrite) mem[Address[5:2]] <= WriteData;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    return (sz == 2'd3) || (sz == 2'd1 && a[0] == 1'b1) || (sz == 2'd2 && a[1:0] != 2'd0);
  endfunction

  function automatic logic [31:0] model_mask(input logic [1:0] sz);
    return (sz == 2'd0) ? 32'h0000_00FF : (sz == 2'd1) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] word, input logic [1:0] sz,
                                             input logic u, input logic [1:0] off);
    logic [31:0] v;
    v = (word >> (8 * int'(off))) & model_mask(sz);
    if (!u && sz == 2'd0 && v[7])  v = v | 32'hFFFF_FF00;
    if (!u && sz == 2'd1 && v[15]) v = v | 32'hFFFF_0000;
    return v;
  endfunction

  function automatic logic [31:0] model_store(input logic [31:0] old, input logic [1:0] sz,
                                              input logic [1:0] off, input logic [31:0] wd);
    int sh;
    sh = 8 * int'(off);
    return (old & ~(model_mask(sz) << sh)) | ((wd & model_mask(sz)) << sh);
  endfunction

  task automatic drive_garbage();
    req_write    = 1'($urandom_range(0, 1));
    req_size     = 2'($urandom_range(0, 3));
    req_unsigned = 1'($urandom_range(0, 1));
    req_addr     = $urandom;
    req_wdata    = $urandom;
  endtask

  // Wait (bounded) for ready at a negedge; called and returns at a negedge
  task automatic wait_ready(input string tag);
    int k;
    k = 0;
    while (req_ready !== 1'b1 && k < 8) begin
      @(negedge clk);
      k++;
    end
    check({tag, "/ready"}, 32'(req_ready), 32'd1);
  endtask

  // One full transaction, checked against the model. Starts and ends at a negedge.
  task automatic xact(input string tag, input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] wd, output logic [31:0] got);
    logic        exp_err;
    int          exp_lat, exp_rd, exp_wr;
    logic [31:0] exp_rdata, exp_wd, old, last_wd;
    int          lat, n_rd, n_wr, n_both, n_abad;
    logic        err;

    exp_err   = model_err(sz, a);
    old       = ref_mem[a[5:2]];
    exp_rd    = (!exp_err && (!w || sz != 2'd2)) ? 1 : 0;
    exp_wr    = (!exp_err && w) ? 1 : 0;
    exp_lat   = exp_err ? 1 : ((w && sz != 2'd2) ? 3 : 2);
    exp_rdata = (!exp_err && !w) ? model_load(old, sz, u, a[1:0]) : 32'h0;
    exp_wd    = model_store(old, sz, a[1:0], wd);
    if (exp_wr == 1) ref_mem[a[5:2]] = exp_wd;

    wait_ready(tag);
    req_valid    = 1'b1;
    req_write    = w;
    req_size     = sz;
    req_unsigned = u;
    req_addr     = a;
    req_wdata    = wd;
    @(negedge clk);
    // keep offering junk while busy: it must be ignored
    drive_garbage();
    lat = 1; n_rd = 0; n_wr = 0; n_both = 0; n_abad = 0; last_wd = 32'h0;
    forever begin
      n_rd += int'(MemRead);
      n_wr += int'(MemWrite);
      if (MemRead && MemWrite) n_both++;
      if ((MemRead || MemWrite) && Address !== {a[31:2], 2'b00}) n_abad++;
      if (MemWrite) last_wd = WriteData;
      if (resp_valid === 1'b1 || lat >= 6) break;
      @(negedge clk);
      drive_garbage();
      lat++;
    end
    req_valid = 1'b0;
    got = resp_rdata;
    err = resp_error;
    check({tag, "/latency"}, 32'(lat), 32'(exp_lat));
    check({tag, "/error"}, 32'(err), 32'(exp_err));
    check({tag, "/rdata"}, got, exp_rdata);
    check({tag, "/n_memread"}, 32'(n_rd), 32'(exp_rd));
    check({tag, "/n_memwrite"}, 32'(n_wr), 32'(exp_wr));
    check({tag, "/rd_wr_overlap"}, 32'(n_both), 32'd0);
    check({tag, "/addr_bad"}, 32'(n_abad), 32'd0);
    check({tag, "/resp_addr"}, Address, {a[31:2], 2'b00});
    if (exp_wr == 1) check({tag, "/writedata"}, last_wd, exp_wd);
    @(negedge clk);
    check({tag, "/pulse_end"}, 32'(resp_valid), 32'd0);
    check({tag, "/idle_ready"}, 32'(req_ready), 32'd1);
    check({tag, "/mem_word"}, mem[a[5:2]], ref_mem[a[5:2]]);
  endtask

  initial begin
    logic [31:0] got;
    logic        w;
    logic [1:0]  sz;
    logic [31:0] a;

    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    rst_n = 1'b0;
    req_valid = 1'b0;
    req_write = 1'b0;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'h0;
    req_wdata = 32'h0;

    // Reset held for two edges: everything quiet
    repeat (2) @(posedge clk);
    @(negedge clk);
    check("rst/req_ready", 32'(req_ready), 32'd0);
    check("rst/resp_valid", 32'(resp_valid), 32'd0);
    check("rst/resp_rdata", resp_rdata, 32'h0);
    check("rst/resp_error", 32'(resp_error), 32'd0);
    check("rst/memread", 32'(MemRead), 32'd0);
    check("rst/memwrite", 32'(MemWrite), 32'd0);
    check("rst/address", Address, 32'h0);
    check("rst/writedata", WriteData, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst/ready_after_release", 32'(req_ready), 32'd1);

    // Word store / load
    xact("sw0", 1'b1, 2'd2, 1'b0, 32'h0, 32'hDEADBEEF, got);
    check("sw0/mem_lit", mem[0], 32'hDEADBEEF);
    xact("lw0", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, got);
    check("lw0/lit", got, 32'hDEADBEEF);

    // Byte read-modify-write and sub-word loads
    xact("sb2", 1'b1, 2'd0, 1'b0, 32'h2, 32'h1234_565A, got);
    check("sb2/mem_lit", mem[0], 32'hDE5ABEEF);
    xact("lbu2", 1'b0, 2'd0, 1'b1, 32'h2, 32'h0, got);
    check("lbu2/lit", got, 32'h0000_005A);
    xact("lb3", 1'b0, 2'd0, 1'b0, 32'h3, 32'h0, got);
    check("lb3/lit", got, 32'hFFFF_FFDE);
    xact("lh2", 1'b0, 2'd1, 1'b0, 32'h2, 32'h0, got);
    check("lh2/lit", got, 32'hFFFF_DE5A);
    xact("lhu2", 1'b0, 2'd1, 1'b1, 32'h2, 32'h0, got);
    check("lhu2/lit", got, 32'h0000_DE5A);
    xact("lh0", 1'b0, 2'd1, 1'b0, 32'h0, 32'h0, got);
    check("lh0/lit", got, 32'hFFFF_BEEF);

    // Errors: no memory cycle, memory untouched
    xact("err_sw6", 1'b1, 2'd2, 1'b0, 32'h6, 32'h1111_1111, got);
    xact("err_lh1", 1'b0, 2'd1, 1'b0, 32'h1, 32'h0, got);
    xact("err_sz3", 1'b1, 2'd3, 1'b0, 32'h0, 32'h2222_2222, got);
    xact("err_sz3ld", 1'b0, 2'd3, 1'b0, 32'h0, 32'h0, got);
    xact("lw_after_err", 1'b0, 2'd2, 1'b0, 32'h4, 32'h0, got);
    xact("lw0_after_err", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, got);
    check("lw0_after_err/lit", got, 32'hDE5ABEEF);

    // Reset during the RD cycle of a sub-word store abandons it
    wait_ready("rst_mid");
    req_valid = 1'b1;
    req_write = 1'b1;
    req_size = 2'd0;
    req_unsigned = 1'b0;
    req_addr = 32'h1;
    req_wdata = 32'h0000_0077;
    @(negedge clk);
    req_valid = 1'b0;
    check("rst_mid/in_rd", 32'(MemRead), 32'd1);
    rst_n = 1'b0;
    @(negedge clk);
    check("rst_mid/no_write", 32'(MemWrite), 32'd0);
    check("rst_mid/no_resp", 32'(resp_valid), 32'd0);
    check("rst_mid/not_ready", 32'(req_ready), 32'd0);
    check("rst_mid/addr_idle", Address, 32'h0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_mid/ready", 32'(req_ready), 32'd1);
    check("rst_mid/no_resp2", 32'(resp_valid), 32'd0);
    check("rst_mid/no_write2", 32'(MemWrite), 32'd0);
    xact("lw0_after_rst", 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, got);
    check("lw0_after_rst/lit", got, 32'hDE5ABEEF);

    // Randomized mix checked against the model
    for (int n = 0; n < 60; n++) begin
      w  = 1'($urandom_range(0, 1));
      sz = 2'($urandom_range(0, 3));
      a  = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (sz == 2'd1) a[0] = 1'b0;
        if (sz == 2'd2) a[1:0] = 2'b00;
      end
      xact($sformatf("rnd%0d", n), w, sz, 1'($urandom_range(0, 1)), a, $urandom, got);
    end

    // Final sweep: every memory word matches the model
    for (int i = 0; i < 16; i++) check($sformatf("final_mem%0d", i), mem[i], ref_mem[i]);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
